if_id_hazard_reg: RTL

- IF/ID pipeline register with integrated load-use hazard detection and branch flush.
- Sits between the fetch stage and the ID/EX register. It feeds the decode stage and forms the 15-bit {rs,rt,rd} address bus that the ID/EX register consumes.
- It uses the ID/EX register's registered MemRead and rt outputs to detect load-use hazards. On a hazard it stalls fetch and injects a control bubble into ID/EX.
- It keeps saturating stall and flush event counters for performance debug.

---
 rtl/if_id_hazard_reg.sv | 80 ++++++++
 1 files changed

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and saturating event counters.
// Latency: one cycle from instr_in/pcplus4_in to instr_out/pcplus4_out; hazard, pc_write and ctrl_bubble are combinational.
// Backpressure: a load-use hazard holds this register and drops pc_write for one cycle; flush overrides the stall.
module if_id_hazard_reg #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pcplus4_in,
  input  logic             flush,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  output logic [31:0]      instr_out,
  output logic [31:0]      pcplus4_out,
  output logic             valid_out,
  output logic [14:0]      regaddr_out,
  output logic             pc_write,
  output logic             ctrl_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic       hazard;

  assign dec_rs      = instr_out[25:21];
  assign dec_rt      = instr_out[20:16];
  assign regaddr_out = {instr_out[25:21], instr_out[20:16], instr_out[15:11]};

  // Load-use detect: the load in ID/EX writes a register the decoding instruction reads.
  // rt is compared regardless of instruction format; occasional false stalls on I-type are harmless.
  // valid_out gates out reset/flush fill so a NOP never stalls; $zero is never a real dependency.
  always_comb begin
    hazard = valid_out & idex_memread & (idex_rt != 5'd0) &
             ((idex_rt == dec_rs) | (idex_rt == dec_rt));
  end

  // Flush wins over a stall: the stalled instruction is squashed, so fetch proceeds and no bubble is needed.
  assign pc_write    = ~hazard | flush;
  assign ctrl_bubble = hazard & ~flush;

  // Pipeline register: reset > flush > hazard hold > normal load.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_out   <= NOP_WORD;
      pcplus4_out <= 32'd0;
      valid_out   <= 1'b0;
    end else if (flush) begin
      instr_out   <= NOP_WORD;
      pcplus4_out <= pcplus4_in;
      valid_out   <= 1'b0;
    end else if (!hazard) begin
      instr_out   <= instr_in;
      pcplus4_out <= pcplus4_in;
      valid_out   <= 1'b1;
    end
  end

  // Saturating performance counters: one stall per cycle a bubble is injected, one flush per flush cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (flush) begin
        if (!(&flush_count)) begin
          flush_count <= flush_count + 1'b1;
        end
      end else if (hazard) begin
        if (!(&stall_count)) begin
          stall_count <= stall_count + 1'b1;
        end
      end
    end
  end

endmodule
